// File: rtl/llsc_monitor_pkg.sv
// -----------------------------------------------------------------------------
// llsc_monitor_pkg
//   Shared constants and types for the LL/SC reservation monitor.
//   - LLSC_ALIGN_BITS / LLSC_TIMEOUT_DEFAULT : default reservation granule and
//     lifetime used by llsc_monitor.
//   - Level constants for write enables, reset and LLbit values.
//   - upd_e : which register-update rule applies in the current cycle.
//   - timer_width() : width of the reservation timeout counter.
// -----------------------------------------------------------------------------
package llsc_monitor_pkg;

  localparam int LLSC_ADDR_W_DEFAULT  = 32;
  localparam int LLSC_ALIGN_BITS      = 2;
  localparam int LLSC_TIMEOUT_DEFAULT = 1024;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;
  localparam logic LLBIT_SET     = 1'b1;
  localparam logic LLBIT_CLEAR   = 1'b0;

  // Register-update rule for one cycle, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    UPD_FLUSH = 3'd0,  // exception/ERET: drop everything, no LLbit write
    UPD_STALL = 3'd1,  // hold the write port; clear events only mark pending
    UPD_LL    = 3'd2,  // LL retires: take a new reservation
    UPD_SC    = 3'd3,  // SC retires (pass or fail): release the reservation
    UPD_CLEAR = 3'd4,  // snoop/timeout clear or a clear deferred by a stall
    UPD_IDLE  = 3'd5   // nothing to write
  } upd_e;

  // Counter width for a given lifetime; a zero lifetime still yields a legal
  // width even though no counter is built in that case.
  function automatic int timer_width(input int timeout);
    return (timeout <= 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/llsc_timeout_ctr.sv
// -----------------------------------------------------------------------------
// llsc_timeout_ctr
//   Reservation lifetime counter. Loaded with TIMEOUT when an LL retires,
//   decremented once per cycle while enabled, saturating at zero.
//   Ports:
//     clk     in  clock, rising edge
//     rst     in  asynchronous, active-high reset
//     load_i  in  reload with TIMEOUT (wins over dec_i)
//     dec_i   in  decrement this cycle (reservation held)
//     zero_o  out count is reaching zero on this cycle's decrement
// -----------------------------------------------------------------------------
module llsc_timeout_ctr
  import llsc_monitor_pkg::*;
#(
  parameter int TIMEOUT = LLSC_TIMEOUT_DEFAULT,
  parameter int W       = timer_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The clear fires in the cycle whose decrement lands on zero, so a
  // reservation is visible for exactly TIMEOUT cycles after the LL retires.
  assign zero_o = dec_i && ((cnt_q == '0) || (cnt_q == ONE));

endmodule

// File: rtl/llsc_monitor.sv
// -----------------------------------------------------------------------------
// llsc_monitor
//   MEM-stage LL/SC reservation monitor sitting directly upstream of the LLbit
//   register. Tracks the reserved word, resolves SC success in the same cycle,
//   gates the SC store, and drives the registered LLbit write port through the
//   MEM/WB boundary (forwarding that in-flight write back into MEM).
//   Ports:
//     clk, rst        clock (rising edge), asynchronous active-high reset
//     stall           MEM/WB hold; LL/SC in MEM do not retire this cycle
//     flush           exception/ERET flush; kills the reservation
//     is_ll, is_sc    LL / SC in MEM
//     mem_addr        effective address of the MEM access
//     mem_we_i        store enable from MEM decode
//     LLbit_i         current LLbit register value
//     snoop_valid     another bus master writes snoop_addr this cycle
//     snoop_addr      address of that write
//     sc_result_o     combinational SC success (value for rt)
//     mem_we_o        mem_we_i, forced low for a failing SC
//     LLbit_we_o      registered LLbit write enable
//     LLbit_value_o   registered LLbit write data
//     resv_valid_o    reservation held
// -----------------------------------------------------------------------------
module llsc_monitor
  import llsc_monitor_pkg::*;
#(
  parameter int ADDR_W     = LLSC_ADDR_W_DEFAULT,
  parameter int ALIGN_BITS = LLSC_ALIGN_BITS,
  parameter int TIMEOUT    = LLSC_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              is_ll,
  input  logic              is_sc,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_we_i,
  input  logic              LLbit_i,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              sc_result_o,
  output logic              mem_we_o,
  output logic              LLbit_we_o,
  output logic              LLbit_value_o,
  output logic              resv_valid_o
);

  localparam int TAG_W = ADDR_W - ALIGN_BITS;

  // Reservation state and the registered LLbit write port.
  logic             resv_valid_q,  resv_valid_d;
  logic [TAG_W-1:0] resv_addr_q,   resv_addr_d;
  logic             clr_pending_q, clr_pending_d;
  logic             llbit_we_q,    llbit_we_d;
  logic             llbit_value_q, llbit_value_d;

  logic             llbit_fwd;
  logic             eff_llbit;
  logic             sc_match;
  logic             snoop_match;
  logic             snoop_hit;
  logic             expire;
  logic             clear_evt;
  logic             ll_retire;
  upd_e             upd;

  // ---------------------------------------------------------------------------
  // Combinational SC resolution and WB forward
  // ---------------------------------------------------------------------------
  assign sc_match    = (mem_addr[ADDR_W-1:ALIGN_BITS] == resv_addr_q);
  assign snoop_match = (snoop_addr[ADDR_W-1:ALIGN_BITS] == resv_addr_q);

  // A write still sitting in MEM/WB is newer than the LLbit register output.
  assign llbit_fwd = llbit_we_q ? llbit_value_q : LLbit_i;
  // The register alone is not trusted: a cleared local reservation masks it.
  assign eff_llbit = llbit_fwd & resv_valid_q;

  assign snoop_hit = snoop_valid & resv_valid_q & snoop_match;

  // A snoop to the reserved word in the same cycle makes the SC fail.
  assign sc_result_o = is_sc & eff_llbit & sc_match & ~snoop_hit;
  assign mem_we_o    = mem_we_i & (~is_sc | sc_result_o);

  // ---------------------------------------------------------------------------
  // Reservation lifetime
  // ---------------------------------------------------------------------------
  assign ll_retire = is_ll & ~stall & ~flush;

  generate
    if (TIMEOUT != 0) begin : g_timeout
      llsc_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .W       (timer_width(TIMEOUT))
      ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .load_i (ll_retire),
        .dec_i  (resv_valid_q),
        .zero_o (expire)
      );
    end else begin : g_no_timeout
      assign expire = 1'b0;
    end
  endgenerate

  // Low address bits never take part in the word-granule compare.
  generate
    if (ALIGN_BITS > 0) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^{mem_addr[ALIGN_BITS-1:0], snoop_addr[ALIGN_BITS-1:0]};
    end
  endgenerate

  assign clear_evt = snoop_hit | expire;

  // ---------------------------------------------------------------------------
  // Update rule selection (priority encoded)
  // ---------------------------------------------------------------------------
  always_comb begin
    upd = UPD_IDLE;
    if (flush) begin
      upd = UPD_FLUSH;
    end else if (stall) begin
      upd = UPD_STALL;
    end else if (is_ll) begin
      upd = UPD_LL;
    end else if (is_sc) begin
      upd = UPD_SC;
    end else if (clear_evt || clr_pending_q) begin
      upd = UPD_CLEAR;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    resv_valid_d  = resv_valid_q;
    resv_addr_d   = resv_addr_q;
    clr_pending_d = clr_pending_q;
    llbit_we_d    = llbit_we_q;
    llbit_value_d = llbit_value_q;

    case (upd)
      UPD_FLUSH: begin
        // The LLbit register clears itself on flush, so no write is issued.
        resv_valid_d  = 1'b0;
        clr_pending_d = 1'b0;
        llbit_we_d    = WRITE_DISABLE;
      end
      UPD_STALL: begin
        // The held write port is idempotent; only remember a clear for later.
        if (clear_evt) begin
          resv_valid_d  = 1'b0;
          clr_pending_d = 1'b1;
        end
      end
      UPD_LL: begin
        // An LL overrides any same-cycle or deferred clear.
        resv_addr_d   = mem_addr[ADDR_W-1:ALIGN_BITS];
        resv_valid_d  = 1'b1;
        clr_pending_d = 1'b0;
        llbit_we_d    = WRITE_ENABLE;
        llbit_value_d = LLBIT_SET;
      end
      UPD_SC, UPD_CLEAR: begin
        // SC retire writes 0 as well, which also satisfies any pending clear.
        resv_valid_d  = 1'b0;
        clr_pending_d = 1'b0;
        llbit_we_d    = WRITE_ENABLE;
        llbit_value_d = LLBIT_CLEAR;
      end
      default: begin
        llbit_we_d = WRITE_DISABLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      resv_valid_q  <= 1'b0;
      resv_addr_q   <= '0;
      clr_pending_q <= 1'b0;
      llbit_we_q    <= WRITE_DISABLE;
      llbit_value_q <= LLBIT_CLEAR;
    end else begin
      resv_valid_q  <= resv_valid_d;
      resv_addr_q   <= resv_addr_d;
      clr_pending_q <= clr_pending_d;
      llbit_we_q    <= llbit_we_d;
      llbit_value_q <= llbit_value_d;
    end
  end

  assign LLbit_we_o    = llbit_we_q;
  assign LLbit_value_o = llbit_value_q;
  assign resv_valid_o  = resv_valid_q;

endmodule
